lcd_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of the LCD controller: it accepts command/image packets from the host over a valid/ready byte stream, buffers a full 6x6 image, and replays each packet to the LCD controller using its cmd/cmd_valid/busy/datain protocol. It also counts the controller's 9-byte window output so the host sees one completion pulse per command. Only one packet is in flight at a time.

---
 rtl/lcd_pkg.sv | 31 +++
 rtl/lcd_cmd_seq_if.sv | 23 ++
 rtl/lcd_img_buf.sv | 21 ++
 rtl/lcd_cmd_seq.sv | 141 ++++++++++++++
 tb/tb_lcd_cmd_seq.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Definitions shared by the LCD command sequencer and the LCD controller:
// command encodings, image/window sizes and the sequencer state encoding.
package lcd_pkg;

  typedef enum logic [2:0] {
    CMD_REFLASH = 3'd0,
    CMD_LOAD    = 3'd1,
    CMD_RIGHT   = 3'd2,
    CMD_LEFT    = 3'd3,
    CMD_UP      = 3'd4,
    CMD_DOWN    = 3'd5
  } cmd_e;

  localparam int PIX = 36;
  localparam int WIN = 9;
  localparam logic [5:0] PIX_LAST = 6'(PIX - 1);
  localparam logic [3:0] WIN_LAST = 4'(WIN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_ISSUE,
    ST_STREAM,
    ST_WAIT
  } state_e;

  function automatic logic cmd_legal(input logic [2:0] c);
    return c <= CMD_DOWN;
  endfunction

endpackage

// File: rtl/lcd_cmd_seq_if.sv
// Host byte stream plus LCD controller command/data/status signals.
interface lcd_cmd_seq_if;
  logic       h_valid;
  logic       h_ready;
  logic [7:0] h_data;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic       busy;
  logic       output_valid;
  logic       seq_done;
  logic       cmd_err;

  modport master (
    output h_valid, h_data, busy, output_valid,
    input  h_ready, cmd, cmd_valid, datain, seq_done, cmd_err
  );

  modport slave (
    input  h_valid, h_data, busy, output_valid,
    output h_ready, cmd, cmd_valid, datain, seq_done, cmd_err
  );
endinterface

// File: rtl/lcd_img_buf.sv
// 36x8 image register file: synchronous write, combinational read, no reset.
module lcd_img_buf
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [5:0] waddr,
  input  logic [7:0] wdata,
  input  logic [5:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [PIX];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_cmd_seq.sv
// Buffers host command/image packets and replays them to the LCD controller,
// counting the controller's window bytes to produce one completion pulse.
module lcd_cmd_seq
  import lcd_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  lcd_cmd_seq_if.slave bus
);

  state_e     state_q, state_d;
  logic [2:0] cmd_q, cmd_d;
  logic [5:0] pix_cnt_q, pix_cnt_d;
  logic [3:0] win_cnt_q, win_cnt_d;
  logic [7:0] datain_q, datain_d;
  logic       h_ready_q, h_ready_d;
  logic       seq_done_q, seq_done_d;
  logic       cmd_err_q, cmd_err_d;

  logic       hs;
  logic       issue_go;
  logic       buf_we;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       unused_hi;

  assign hs        = bus.h_valid & h_ready_q;
  assign issue_go  = (state_q == ST_ISSUE) & ~bus.busy;
  assign unused_hi = ^bus.h_data[7:3];

  lcd_img_buf u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (pix_cnt_q),
    .wdata (bus.h_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cmd_q      <= 3'd0;
      pix_cnt_q  <= 6'd0;
      win_cnt_q  <= 4'd0;
      datain_q   <= 8'd0;
      h_ready_q  <= 1'b0;
      seq_done_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      pix_cnt_q  <= pix_cnt_d;
      win_cnt_q  <= win_cnt_d;
      datain_q   <= datain_d;
      h_ready_q  <= h_ready_d;
      seq_done_q <= seq_done_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (hs) begin
          if (bus.h_data[2:0] == CMD_LOAD)     state_d = ST_RECV;
          else if (cmd_legal(bus.h_data[2:0])) state_d = ST_ISSUE;
        end
      ST_RECV:
        if (hs && pix_cnt_q == PIX_LAST) state_d = ST_ISSUE;
      ST_ISSUE:
        if (!bus.busy) state_d = (cmd_q == CMD_LOAD) ? ST_STREAM : ST_WAIT;
      ST_STREAM:
        if (pix_cnt_q == PIX_LAST) state_d = ST_WAIT;
      ST_WAIT:
        if (bus.output_valid && win_cnt_q == WIN_LAST) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // datain is preloaded one cycle ahead so buf[k] appears k+1 cycles after the strobe.
  always_comb begin
    cmd_d      = cmd_q;
    pix_cnt_d  = pix_cnt_q;
    win_cnt_d  = win_cnt_q;
    datain_d   = datain_q;
    seq_done_d = 1'b0;
    cmd_err_d  = 1'b0;
    buf_we     = 1'b0;
    rd_addr    = 6'd0;
    h_ready_d  = (state_d == ST_IDLE) || (state_d == ST_RECV);

    unique case (state_q)
      ST_IDLE:
        if (hs) begin
          cmd_d     = bus.h_data[2:0];
          pix_cnt_d = 6'd0;
          cmd_err_d = ~cmd_legal(bus.h_data[2:0]);
        end
      ST_RECV:
        if (hs) begin
          buf_we    = 1'b1;
          pix_cnt_d = (pix_cnt_q == PIX_LAST) ? 6'd0 : pix_cnt_q + 6'd1;
        end
      ST_ISSUE:
        if (issue_go) begin
          pix_cnt_d = 6'd0;
          win_cnt_d = 4'd0;
          if (cmd_q == CMD_LOAD) datain_d = rd_data;
        end
      ST_STREAM:
        if (pix_cnt_q == PIX_LAST) begin
          win_cnt_d = 4'd0;
        end else begin
          rd_addr   = pix_cnt_q + 6'd1;
          pix_cnt_d = pix_cnt_q + 6'd1;
          datain_d  = rd_data;
        end
      ST_WAIT:
        if (bus.output_valid) begin
          if (win_cnt_q == WIN_LAST) begin
            seq_done_d = 1'b1;
            win_cnt_d  = 4'd0;
          end else begin
            win_cnt_d = win_cnt_q + 4'd1;
          end
        end
      default: ;
    endcase
  end

  // The strobe follows the live busy input so a command leaves on the first idle cycle.
  assign bus.cmd_valid = issue_go;
  assign bus.cmd       = cmd_q;
  assign bus.datain    = datain_q;
  assign bus.h_ready   = h_ready_q;
  assign bus.seq_done  = seq_done_q;
  assign bus.cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Bench for lcd_cmd_seq: acts as host and as LCD controller, checks every
// cycle against a packet-level model of the expected sequencer behaviour.
module tb_lcd_cmd_seq;
  import lcd_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lcd_cmd_seq_if bus();

  lcd_cmd_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] img [PIX];
  logic [7:0] exp_din = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic observe(input string ph, input logic exp_ready, input logic exp_cv,
                         input logic exp_done);
    @(negedge clk);
    chk({ph, ":h_ready"}, 32'(bus.h_ready), 32'(exp_ready));
    chk({ph, ":cmd_valid"}, 32'(bus.cmd_valid), 32'(exp_cv));
    chk({ph, ":seq_done"}, 32'(bus.seq_done), 32'(exp_done));
    chk({ph, ":cmd_err"}, 32'(bus.cmd_err), 32'd0);
    chk({ph, ":datain"}, 32'(bus.datain), 32'(exp_din));
  endtask

  task automatic chk_reset_vals(input string ph);
    @(negedge clk);
    chk({ph, ":h_ready"}, 32'(bus.h_ready), 32'd0);
    chk({ph, ":cmd"}, 32'(bus.cmd), 32'd0);
    chk({ph, ":cmd_valid"}, 32'(bus.cmd_valid), 32'd0);
    chk({ph, ":datain"}, 32'(bus.datain), 32'd0);
    chk({ph, ":seq_done"}, 32'(bus.seq_done), 32'd0);
    chk({ph, ":cmd_err"}, 32'(bus.cmd_err), 32'd0);
  endtask

  // One full packet: command byte, optional 36-byte payload, issue, stream, window.
  task automatic do_packet(input logic [7:0] cbyte, input bit rand_data, input bit gaps,
                           input int busy_cyc, input int wgap_max, input int abort_at);
    logic [2:0] c;
    logic [7:0] d;
    c = cbyte[2:0];
    bus.h_valid = 1'b1;
    bus.h_data  = cbyte;
    bus.busy    = 1'($urandom);
    observe("cmd_byte", 1'b1, 1'b0, 1'b0);
    cyc_end();
    if (c == CMD_LOAD) begin
      for (int k = 0; k < PIX; k++) begin
        if (gaps) begin
          bus.h_valid = 1'b0;
          bus.h_data  = 8'($urandom);
          observe("recv_gap", 1'b1, 1'b0, 1'b0);
          cyc_end();
        end
        d = rand_data ? 8'($urandom) : 8'(k);
        img[k] = d;
        bus.h_valid = 1'b1;
        bus.h_data  = d;
        bus.busy    = 1'($urandom);
        observe("recv", 1'b1, 1'b0, 1'b0);
        cyc_end();
      end
    end
    for (int b = 0; b < busy_cyc; b++) begin
      bus.h_valid      = 1'($urandom);
      bus.h_data       = 8'($urandom);
      bus.output_valid = 1'($urandom);
      bus.busy         = 1'b1;
      observe("issue_busy", 1'b0, 1'b0, 1'b0);
      cyc_end();
    end
    bus.busy = 1'b0;
    bus.output_valid = 1'($urandom);
    observe("issue", 1'b0, 1'b1, 1'b0);
    chk("issue:cmd", 32'(bus.cmd), 32'(c));
    cyc_end();
    if (c == CMD_LOAD) begin
      for (int k = 0; k < PIX; k++) begin
        bus.h_valid      = 1'($urandom);
        bus.busy         = 1'($urandom);
        bus.output_valid = 1'($urandom);
        if (k == abort_at) begin
          reset   = 1'b1;
          exp_din = 8'd0;
          chk_reset_vals("abort");
          return;
        end
        exp_din = img[k];
        observe("stream", 1'b0, 1'b0, 1'b0);
        cyc_end();
      end
    end
    bus.h_valid = 1'b0;
    for (int p = 0; p < WIN; p++) begin
      int g;
      g = $urandom_range(0, wgap_max);
      for (int i = 0; i < g; i++) begin
        bus.output_valid = 1'b0;
        bus.busy         = 1'($urandom);
        observe("wait_gap", 1'b0, 1'b0, 1'b0);
        cyc_end();
      end
      bus.output_valid = 1'b1;
      observe("wait_ov", 1'b0, 1'b0, 1'b0);
      cyc_end();
    end
    bus.output_valid = 1'b0;
    observe("done", 1'b1, 1'b0, 1'b1);
    cyc_end();
    observe("post_done", 1'b1, 1'b0, 1'b0);
    cyc_end();
  endtask

  task automatic do_illegal(input logic [7:0] b);
    bus.h_valid = 1'b1;
    bus.h_data  = b;
    observe("ill_byte", 1'b1, 1'b0, 1'b0);
    cyc_end();
    bus.h_valid = 1'b0;
    @(negedge clk);
    chk("ill:cmd_err", 32'(bus.cmd_err), 32'd1);
    chk("ill:cmd_valid", 32'(bus.cmd_valid), 32'd0);
    chk("ill:h_ready", 32'(bus.h_ready), 32'd1);
    cyc_end();
    observe("ill_post", 1'b1, 1'b0, 1'b0);
    cyc_end();
  endtask

  initial begin
    logic [2:0] c;
    bus.h_valid      = 1'b0;
    bus.h_data       = 8'd0;
    bus.busy         = 1'b0;
    bus.output_valid = 1'b0;

    chk_reset_vals("reset");
    cyc_end();
    reset = 1'b0;
    cyc_end();
    observe("after_reset", 1'b1, 1'b0, 1'b0);
    cyc_end();

    // LOAD of 0..35, no busy, back-to-back window bytes
    do_packet(8'h01, 1'b0, 1'b0, 0, 0, -1);
    // RIGHT with busy held for 5 cycles
    do_packet(8'h02, 1'b0, 1'b0, 5, 2, -1);
    // illegal bytes, upper bits set on one of them
    do_illegal(8'h07);
    do_illegal(8'hF6);
    // LOAD with h_valid gapped every other cycle
    do_packet(8'h01, 1'b1, 1'b1, 2, 3, -1);

    for (int i = 0; i < 6; i++) begin
      c = 3'($urandom_range(0, 5));
      do_packet({5'($urandom), c}, 1'b1, 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 2), -1);
    end

    // reset while streaming byte 20, then a REFLASH runs normally
    do_packet(8'h01, 1'b1, 1'b0, 0, 0, 20);
    bus.output_valid = 1'b0;
    bus.h_valid      = 1'b0;
    cyc_end();
    reset = 1'b0;
    cyc_end();
    observe("after_abort", 1'b1, 1'b0, 1'b0);
    cyc_end();
    do_packet(8'h00, 1'b0, 1'b0, 1, 1, -1);

    // stray window bytes while idle must not count toward the next command
    for (int i = 0; i < 5; i++) begin
      bus.output_valid = 1'b1;
      observe("stray", 1'b1, 1'b0, 1'b0);
      cyc_end();
    end
    bus.output_valid = 1'b0;
    do_packet(8'h04, 1'b0, 1'b0, 0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
